// File: rtl/slow_clk_monitor_if.sv
// Signal bundle between the slow-clock monitor and its consumers: the monitored
// clock and enable go in, edge ticks, period measurement and health status come out.
interface slow_clk_monitor_if #(
  parameter int CW = 4
);
  logic          slow_clk_in;
  logic          enable;
  logic          tick_rise;
  logic          tick_fall;
  logic [CW-1:0] period_count;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic [7:0]    error_count;

  modport master (
    output slow_clk_in, enable,
    input  tick_rise, tick_fall, period_count, period_valid, locked, timeout, error_count
  );

  modport slave (
    input  slow_clk_in, enable,
    output tick_rise, tick_fall, period_count, period_valid, locked, timeout, error_count
  );
endinterface

// File: rtl/slow_clk_monitor.sv
// Samples a slow toggling clock in the clk domain, emits edge ticks, measures the
// rise-to-rise period and tracks lock / timeout / error health of the divided clock.
module slow_clk_monitor #(
  parameter int INPUT_FREQUENCY    = 50000000,
  parameter int EXPECTED_FREQUENCY = 1,
  parameter int TOLERANCE_CYCLES   = 1000,
  parameter int SYNC_STAGES        = 2
) (
  input logic               clk,
  input logic               reset,
  slow_clk_monitor_if.slave mon
);
  localparam int P    = INPUT_FREQUENCY / EXPECTED_FREQUENCY;
  localparam int T    = TOLERANCE_CYCLES;
  localparam int CW   = $clog2(P + T + 1);
  localparam int LO_I = (T >= P) ? 1 : P - T;
  localparam logic [CW:0] LO = (CW+1)'(LO_I);
  localparam logic [CW:0] HI = (CW+1)'(P + T);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_MEASURE, S_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_rise_q, tick_fall_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          period_q, period_d;
  logic                   pvalid_q, pvalid_d;
  logic                   timeout_q, timeout_d;
  logic                   locked_q;
  logic [7:0]             err_q, err_d;
  logic                   err_inc;
  logic                   sync_out, rise, fall, in_window, at_limit;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_out & ~hist_q;
  assign fall      = ~sync_out & hist_q;
  assign in_window = ({1'b0, cnt_q} >= LO) && ({1'b0, cnt_q} <= HI);
  assign at_limit  = ({1'b0, cnt_q} == HI);

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    timeout_d = 1'b0;
    err_inc   = 1'b0;
    if (!mon.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
          cnt_d   = rise ? CW'(1) : '0;
        end
        S_ACQUIRE: begin
          cnt_d = '0;
          if (rise) begin
            // First edge only opens the measurement; no period exists yet.
            state_d = S_MEASURE;
            cnt_d   = CW'(1);
          end
        end
        S_MEASURE, S_LOCKED: begin
          if (rise) begin
            cnt_d    = CW'(1);
            period_d = cnt_q;
            pvalid_d = 1'b1;
            if (in_window) begin
              state_d = S_LOCKED;
            end else begin
              state_d = S_MEASURE;
              err_inc = 1'b1;
            end
          end else if (at_limit) begin
            // A rise on this same cycle would have been taken above, so P+T is in window.
            state_d   = S_ACQUIRE;
            cnt_d     = '0;
            timeout_d = 1'b1;
            err_inc   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // NOTE: clocked state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      pvalid_q    <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], mon.slow_clk_in};
      hist_q      <= sync_out;
      tick_rise_q <= rise;
      tick_fall_q <= fall;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pvalid_q    <= pvalid_d;
      timeout_q   <= timeout_d;
      locked_q    <= (state_d == S_LOCKED);
      err_q       <= err_d;
    end
  end

  assign mon.tick_rise    = tick_rise_q;
  assign mon.tick_fall    = tick_fall_q;
  assign mon.period_count = period_q;
  assign mon.period_valid = pvalid_q;
  assign mon.locked       = locked_q;
  assign mon.timeout      = timeout_q;
  assign mon.error_count  = err_q;
endmodule

// File: tb/tb_slow_clk_monitor.sv
// Drives slow_clk_monitor with directed and randomized slow-clock waveforms and compares
// every cycle against an event-timing model built from the edge times the bench itself generates.
module tb_slow_clk_monitor;
  localparam int P  = 10;
  localparam int T  = 2;
  localparam int LO = P - T;
  localparam int HI = P + T;
  localparam int CW = $clog2(P + T + 1);

  localparam int M_OFF  = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slow_clk_monitor_if #(.CW(CW)) mon();

  slow_clk_monitor #(
    .INPUT_FREQUENCY   (100),
    .EXPECTED_FREQUENCY(10),
    .TOLERANCE_CYCLES  (2),
    .SYNC_STAGES       (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (mon)
  );

  int total  = 0;
  int passed = 0;
  int cycle  = 0;

  // Reference model: sampled input history plus time of the last counted rise.
  bit hist[$];
  int mode     = M_OFF;
  int last     = 0;
  bit m_rise   = 0, m_fall = 0, m_valid = 0, m_timeout = 0, m_locked = 0;
  int m_period = 0;
  int m_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_update(input bit rst, input bit en, input bit s);
    if (rst) begin
      hist = '{0, 0, 0, 0};
      m_rise = 0; m_fall = 0; m_valid = 0; m_timeout = 0; m_locked = 0;
      m_period = 0; m_err = 0; mode = M_OFF;
      return;
    end
    hist.push_front(s);
    void'(hist.pop_back());
    // A sample reaches the edge detector two clocks after being taken.
    m_rise    = hist[2] & ~hist[3];
    m_fall    = ~hist[2] & hist[3];
    m_valid   = 0;
    m_timeout = 0;
    if (!en) begin
      mode     = M_OFF;
      m_locked = 0;
    end else begin
      case (mode)
        M_OFF: mode = M_WAIT;
        M_WAIT: if (m_rise) begin
          mode = M_RUN;
          last = cycle;
        end
        default: begin
          if (m_rise) begin
            int d;
            d        = cycle - last;
            m_valid  = 1;
            m_period = d;
            m_locked = (d >= LO && d <= HI);
            if (!m_locked) bump_err();
            last = cycle;
          end else if (cycle - last == HI) begin
            m_timeout = 1;
            m_locked  = 0;
            bump_err();
            mode = M_WAIT;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit s);
    reset           = rst;
    mon.enable      = en;
    mon.slow_clk_in = s;
    @(posedge clk);
    cycle++;
    model_update(rst, en, s);
    #1;
    check("tick_rise",    32'(mon.tick_rise),    32'(m_rise));
    check("tick_fall",    32'(mon.tick_fall),    32'(m_fall));
    check("period_valid", 32'(mon.period_valid), 32'(m_valid));
    check("timeout",      32'(mon.timeout),      32'(m_timeout));
    check("locked",       32'(mon.locked),       32'(m_locked));
    check("period_count", 32'(mon.period_count), 32'(m_period));
    check("error_count",  32'(mon.error_count),  32'(m_err));
  endtask

  // One slow-clock period of per cycles; rnd picks a random high/low split.
  task automatic wave(input int per, input bit en, input bit rnd);
    int hi_len;
    hi_len = rnd ? int'($urandom_range(per - 1, 1)) : per / 2;
    for (int i = 0; i < hi_len; i++) step(0, en, 1);
    for (int i = hi_len; i < per; i++) step(0, en, 0);
  endtask

  initial begin
    hist = '{0, 0, 0, 0};
    // Reset with the slow clock held high: exactly one rise once released.
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 6; i++) wave(10, 1, 0);
    check("locked_after_nominal", 32'(mon.locked), 32'd1);

    // One long period breaks lock, nominal periods relock.
    wave(14, 1, 0);
    for (int i = 0; i < 3; i++) wave(10, 1, 0);

    // Stuck low -> timeout, then reacquire.
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) wave(10, 1, 0);

    // Window edges and one just outside.
    wave(8, 1, 1);
    wave(12, 1, 1);
    wave(10, 1, 1);
    wave(7, 1, 1);
    wave(10, 1, 1);
    wave(10, 1, 1);
    for (int i = 0; i < 20; i++) wave(int'($urandom_range(12, 8)), 1, 1);

    // Disable while locked, then re-enable.
    for (int i = 0; i < 2; i++) wave(10, 0, 0);
    for (int i = 0; i < 4; i++) wave(10, 1, 0);

    // Reset mid-period.
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(1, 1, 1);
    for (int i = 0; i < 2; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) wave(10, 1, 0);

    // Many short periods drive the error counter into saturation.
    for (int i = 0; i < 300; i++) wave(int'($urandom_range(7, 3)), 1, 1);
    check("error_saturated", 32'(mon.error_count), 32'd255);
    for (int i = 0; i < 4; i++) wave(10, 1, 0);
    check("relock_after_errors", 32'(mon.locked), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
